// File: rtl/ps2_rx_if.sv
// ps2_rx_if: bundle between the PS/2 receiver and its environment.
//   PS2C, PS2D : raw PS/2 clock/data lines (device -> host, asynchronous)
//   Ack        : consumer acknowledge, clears V
//   D, V       : received byte and level-valid flag
//   PE, FE, OVR: one-cycle parity / framing-timeout / overrun pulses
//   Busy       : frame in progress
// master = receiver side, slave = keyboard/consumer side.
interface ps2_rx_if;
  logic       PS2C;
  logic       PS2D;
  logic       Ack;
  logic [7:0] D;
  logic       V;
  logic       PE;
  logic       FE;
  logic       OVR;
  logic       Busy;

  modport master (
    input  PS2C, PS2D, Ack,
    output D, V, PE, FE, OVR, Busy
  );

  modport slave (
    output PS2C, PS2D, Ack,
    input  D, V, PE, FE, OVR, Busy
  );
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver (start, 8 data LSB first,
// odd parity, stop). Lines are synchronized, glitch filtered, and sampled
// on each filtered falling PS2C edge. Good bytes are offered on D/V until
// acknowledged; errors are reported as single-cycle pulses.
// Ports:
//   C   : system clock, all state on posedge
//   R   : asynchronous active-high reset
//   bus : ps2_rx_if.master (PS2C, PS2D, Ack in; D, V, PE, FE, OVR, Busy out)
module ps2_rx #(
  parameter int unsigned FILT    = 4,
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned TW      = 16
) (
  input logic      C,
  input logic      R,
  ps2_rx_if.master bus
);

  localparam int unsigned FW = $clog2(FILT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 = PS2C, index 1 = PS2D
  logic [1:0]    pins;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          c_prev;
  logic          se;
  logic          din;

  state_t        state;
  logic [7:0]    sh;
  logic [2:0]    bitcnt;
  logic          par;
  logic [TW-1:0] tmo;

  logic [7:0]    d_q;
  logic          v_q;
  logic          pe_q;
  logic          fe_q;
  logic          ovr_q;
  logic          busy_q;

  assign pins = {bus.PS2D, bus.PS2C};

  // Filtered level flips only after FILT consecutive samples that differ
  // from it; any agreeing sample restarts the run.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      sync1 <= '1;
      sync2 <= '1;
      filt  <= '1;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (fcnt[i] == FW'(FILT - 1)) begin
            filt[i] <= sync2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) c_prev <= 1'b1;
    else   c_prev <= filt[0];
  end

  assign se  = c_prev & ~filt[0];
  assign din = filt[1];

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state  <= IDLE;
      sh     <= '0;
      bitcnt <= '0;
      par    <= 1'b0;
      tmo    <= '0;
      d_q    <= '0;
      v_q    <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      ovr_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      pe_q  <= 1'b0;
      fe_q  <= 1'b0;
      ovr_q <= 1'b0;

      // Ack clear first so a frame completing this cycle keeps V high.
      if (bus.Ack && v_q) v_q <= 1'b0;

      if (state == IDLE) tmo <= '0;
      else if (se)       tmo <= '0;
      else               tmo <= tmo + 1'b1;

      case (state)
        IDLE: begin
          if (se) begin
            if (!din) begin
              state  <= DATA;
              bitcnt <= '0;
              busy_q <= 1'b1;
            end else begin
              fe_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (se) begin
            sh <= {din, sh[7:1]};
            if (bitcnt == 3'd7) state <= PARITY;
            else                bitcnt <= bitcnt + 1'b1;
          end
        end
        PARITY: begin
          if (se) begin
            par   <= din;
            state <= STOP;
          end
        end
        STOP: begin
          if (se) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (!din) begin
              fe_q <= 1'b1;
            end else if (!(^{sh, par})) begin
              pe_q <= 1'b1;
            end else begin
              d_q   <= sh;
              v_q   <= 1'b1;
              ovr_q <= v_q & ~bus.Ack;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase

      // Timeout abort; an SE in the same cycle takes precedence.
      if (state != IDLE && !se && tmo == TW'(TIMEOUT - 1)) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        fe_q   <= 1'b1;
      end
    end
  end

  assign bus.D    = d_q;
  assign bus.V    = v_q;
  assign bus.PE   = pe_q;
  assign bus.FE   = fe_q;
  assign bus.OVR  = ovr_q;
  assign bus.Busy = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;
  localparam int unsigned FILT    = 4;
  localparam int unsigned TIMEOUT = 20000;
  localparam int          HS      = 20;   // fast PS2C half period

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_rx_if bus();

  ps2_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT), .TW(16)) dut (
    .C   (clk),
    .R   (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  int   pe_cnt = 0, fe_cnt = 0, ovr_cnt = 0, multi_cnt = 0;
  int   v_rise_cyc = 0, fe_cyc = 0, last_fall_cyc = 0;
  logic v_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.PE === 1'b1)  pe_cnt  = pe_cnt + 1;
    if (bus.FE === 1'b1)  begin fe_cnt = fe_cnt + 1; fe_cyc = cyc; end
    if (bus.OVR === 1'b1) ovr_cnt = ovr_cnt + 1;
    if ((int'(bus.PE === 1'b1) + int'(bus.FE === 1'b1) + int'(bus.OVR === 1'b1)) > 1)
      multi_cnt = multi_cnt + 1;
    if (bus.V === 1'b1 && v_prev !== 1'b1) v_rise_cyc = cyc;
    v_prev = bus.V;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int half, input logic glitch, input logic ack_end);
    bus.PS2D = b;
    if (glitch) begin
      tick(2);
      bus.PS2C = 1'b0;
      tick(FILT - 1);
      bus.PS2C = 1'b1;
      tick(half - 1 - FILT);
    end else begin
      tick(half);
    end
    bus.PS2C = 1'b0;
    last_fall_cyc = cyc;
    if (ack_end) begin
      tick(6);
      bus.Ack = 1'b1;
      tick(1);
      bus.Ack = 1'b0;
      tick(half - 7);
    end else begin
      tick(half);
    end
    bus.PS2C = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int half, input logic glitch, input logic ack_end);
    send_bit(1'b0, half, glitch, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], half, glitch, 1'b0);
    send_bit(par, half, glitch, 1'b0);
    send_bit(stop, half, glitch, ack_end);
    bus.PS2D = 1'b1;
    tick(20);
  endtask

  task automatic ack_once();
    bus.Ack = 1'b1;
    tick(1);
    bus.Ack = 1'b0;
    tick(1);
  endtask

  int pe0, fe0, ovr0, lat;

  initial begin
    bus.PS2C = 1'b1;
    bus.PS2D = 1'b1;
    bus.Ack  = 1'b0;
    rst      = 1'b1;
    tick(3);
    chk("rst_D",    32'(bus.D),    32'h00);
    chk("rst_V",    32'(bus.V),    32'd0);
    chk("rst_Busy", 32'(bus.Busy), 32'd0);
    chk("rst_err",  32'({bus.PE, bus.FE, bus.OVR}), 32'd0);
    rst = 1'b0;
    tick(5);

    // good frame 0x1C, slow clock
    pe0 = pe_cnt; fe0 = fe_cnt; ovr0 = ovr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 500, 1'b0, 1'b0);
    chk("good1_V", 32'(bus.V), 32'd1);
    chk("good1_D", 32'(bus.D), 32'h1C);
    lat = v_rise_cyc - last_fall_cyc;
    chk("good1_lat", 32'(lat >= 6 && lat <= 8), 32'd1);
    chk("good1_err", 32'((pe_cnt - pe0) + (fe_cnt - fe0) + (ovr_cnt - ovr0)), 32'd0);
    ack_once();
    chk("ack_V", 32'(bus.V), 32'd0);
    chk("ack_D", 32'(bus.D), 32'h1C);

    // parity error on 0x1C
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, HS, 1'b0, 1'b0);
    chk("par_PE",  32'(pe_cnt - pe0), 32'd1);
    chk("par_FE",  32'(fe_cnt - fe0), 32'd0);
    chk("par_V",   32'(bus.V), 32'd0);
    chk("par_D",   32'(bus.D), 32'h1C);

    // 0xF0 with parity 1 is good
    send_frame(8'hF0, 1'b1, 1'b1, HS, 1'b0, 1'b0);
    chk("f0_V", 32'(bus.V), 32'd1);
    chk("f0_D", 32'(bus.D), 32'hF0);
    ack_once();

    // stop bit 0 on 0x55
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h55, 1'b1, 1'b0, HS, 1'b0, 1'b0);
    chk("stop_FE", 32'(fe_cnt - fe0), 32'd1);
    chk("stop_PE", 32'(pe_cnt - pe0), 32'd0);
    chk("stop_V",  32'(bus.V), 32'd0);
    chk("stop_D",  32'(bus.D), 32'hF0);

    // bad start bit
    fe0 = fe_cnt;
    send_bit(1'b1, HS, 1'b0, 1'b0);
    tick(HS);
    chk("start_FE",   32'(fe_cnt - fe0), 32'd1);
    chk("start_Busy", 32'(bus.Busy), 32'd0);

    // timeout after 4 falling edges
    fe0 = fe_cnt;
    send_bit(1'b0, HS, 1'b0, 1'b0);
    send_bit(1'b1, HS, 1'b0, 1'b0);
    send_bit(1'b0, HS, 1'b0, 1'b0);
    send_bit(1'b1, HS, 1'b0, 1'b0);
    chk("tmo_busy_before", 32'(bus.Busy), 32'd1);
    tick(TIMEOUT + 10);
    chk("tmo_FE", 32'(fe_cnt - fe0), 32'd1);
    lat = fe_cyc - last_fall_cyc;
    chk("tmo_lat", 32'(lat >= int'(TIMEOUT) + 5 && lat <= int'(TIMEOUT) + 9), 32'd1);
    chk("tmo_Busy", 32'(bus.Busy), 32'd0);
    chk("tmo_V", 32'(bus.V), 32'd0);
    send_frame(8'h29, 1'b0, 1'b1, HS, 1'b0, 1'b0);
    chk("post_tmo_V", 32'(bus.V), 32'd1);
    chk("post_tmo_D", 32'(bus.D), 32'h29);
    ack_once();

    // overrun
    ovr0 = ovr_cnt;
    send_frame(8'h12, 1'b1, 1'b1, HS, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, HS, 1'b0, 1'b0);
    chk("ovr_OVR", 32'(ovr_cnt - ovr0), 32'd1);
    chk("ovr_D",   32'(bus.D), 32'h34);
    chk("ovr_V",   32'(bus.V), 32'd1);
    ack_once();

    // Ack coincident with completion
    ovr0 = ovr_cnt;
    send_frame(8'h12, 1'b1, 1'b1, HS, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, HS, 1'b0, 1'b1);
    chk("ackc_OVR", 32'(ovr_cnt - ovr0), 32'd0);
    chk("ackc_V",   32'(bus.V), 32'd1);
    chk("ackc_D",   32'(bus.D), 32'h34);
    ack_once();

    // short PS2C glitches inside a frame
    pe0 = pe_cnt; fe0 = fe_cnt; ovr0 = ovr_cnt;
    send_frame(8'hAA, 1'b1, 1'b1, HS, 1'b1, 1'b0);
    chk("glitch_V",   32'(bus.V), 32'd1);
    chk("glitch_D",   32'(bus.D), 32'hAA);
    chk("glitch_err", 32'((pe_cnt - pe0) + (fe_cnt - fe0) + (ovr_cnt - ovr0)), 32'd0);

    // reset mid-frame (V still set from 0xAA)
    send_bit(1'b0, HS, 1'b0, 1'b0);
    send_bit(1'b1, HS, 1'b0, 1'b0);
    send_bit(1'b0, HS, 1'b0, 1'b0);
    send_bit(1'b1, HS, 1'b0, 1'b0);
    send_bit(1'b1, HS, 1'b0, 1'b0);
    pe0 = pe_cnt; fe0 = fe_cnt; ovr0 = ovr_cnt;
    rst = 1'b1;
    tick(2);
    chk("mid_rst_D",    32'(bus.D),    32'h00);
    chk("mid_rst_V",    32'(bus.V),    32'd0);
    chk("mid_rst_Busy", 32'(bus.Busy), 32'd0);
    rst = 1'b0;
    bus.PS2D = 1'b1;
    tick(10);
    chk("mid_rst_err", 32'((pe_cnt - pe0) + (fe_cnt - fe0) + (ovr_cnt - ovr0)), 32'd0);
    send_frame(8'h0E, 1'b0, 1'b1, HS, 1'b0, 1'b0);
    chk("post_rst_V", 32'(bus.V), 32'd1);
    chk("post_rst_D", 32'(bus.D), 32'h0E);

    chk("exclusive_pulses", 32'(multi_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
